// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard unit.
// Forward select codes, destination-tag record and the tag match rule.
package hazard_pkg;

    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [1:0]            fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_MEM = 2'b01;
    localparam fwd_sel_t FWD_WB  = 2'b10;

    typedef struct packed {
        logic      valid;
        reg_addr_t rd;
        logic      reg_write;
        logic      mem_read;
    } tag_rec_t;

    localparam tag_rec_t TAG_BUBBLE = '0;

    // x0 is hardwired, so it never creates a dependency
    function automatic logic tag_match(tag_rec_t r, reg_addr_t rs);
        return r.valid && r.reg_write && (r.rd == rs) && (rs != '0);
    endfunction

    // Newest producer wins when both older stages hold the same rd
    function automatic fwd_sel_t fwd_pick(logic in_ex, logic in_mem);
        if (in_ex) begin
            return FWD_MEM;
        end else if (in_mem) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Handshake bundle between the pipeline datapath and the hazard unit.
// master = datapath side, slave = hazard unit side.
interface hazard_unit_if;
    import hazard_pkg::*;

    logic      id_valid;
    reg_addr_t id_rs1;
    reg_addr_t id_rs2;
    reg_addr_t id_rd;
    logic      id_reg_write;
    logic      id_mem_read;
    logic      ex_branch_taken;

    fwd_sel_t  fwd_a_op;
    fwd_sel_t  fwd_b_op;
    logic      stall_if;
    logic      stall_id;
    logic      flush_id;
    logic      flush_ex;

    modport master (
        output id_valid,
        output id_rs1,
        output id_rs2,
        output id_rd,
        output id_reg_write,
        output id_mem_read,
        output ex_branch_taken,
        input  fwd_a_op,
        input  fwd_b_op,
        input  stall_if,
        input  stall_id,
        input  flush_id,
        input  flush_ex
    );

    modport slave (
        input  id_valid,
        input  id_rs1,
        input  id_rs2,
        input  id_rd,
        input  id_reg_write,
        input  id_mem_read,
        input  ex_branch_taken,
        output fwd_a_op,
        output fwd_b_op,
        output stall_if,
        output stall_id,
        output flush_id,
        output flush_ex
    );

endinterface

// File: rtl/hazard_tag_pipe.sv
// Destination-tag shadow of the EX/MEM/WB pipeline registers.
// A flush inserts a bubble into EX; older records always advance.
module hazard_tag_pipe
    import hazard_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     flush,
    input  tag_rec_t id_rec,
    output tag_rec_t ex_rec,
    output tag_rec_t mem_rec,
    output tag_rec_t wb_rec
);

    tag_rec_t ex_d, ex_q;
    tag_rec_t mem_d, mem_q;
    tag_rec_t wb_d, wb_q;

    // Shift records one stage down; bubble replaces the ID entry on flush
    always_comb begin
        ex_d  = flush ? TAG_BUBBLE : id_rec;
        mem_d = ex_q;
        wb_d  = mem_q;
    end

    // Record registers, cleared to bubbles on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= TAG_BUBBLE;
            mem_q <= TAG_BUBBLE;
            wb_q  <= TAG_BUBBLE;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign ex_rec  = ex_q;
    assign mem_rec = mem_q;
    assign wb_rec  = wb_q;

endmodule

// File: rtl/hazard_unit.sv
// Forwarding select, load-use stall and branch flush control.
// Define FORWARDING_EN for bypassing; otherwise ID stalls on EX/MEM producers.
module hazard_unit
    import hazard_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    hazard_unit_if.slave hz
);

    tag_rec_t id_rec;
    tag_rec_t ex_rec;
    tag_rec_t mem_rec;
    tag_rec_t wb_rec;

    logic rs1_ex, rs2_ex;
    logic rs1_mem, rs2_mem;
    logic raw_stall;
    logic flush_ex;
    logic unused_bits;

    // Tag of the instruction leaving ID
    always_comb begin
        id_rec           = TAG_BUBBLE;
        id_rec.valid     = hz.id_valid;
        id_rec.rd        = hz.id_rd;
        id_rec.reg_write = hz.id_reg_write;
        id_rec.mem_read  = hz.id_mem_read;
    end

    hazard_tag_pipe u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush_ex),
        .id_rec  (id_rec),
        .ex_rec  (ex_rec),
        .mem_rec (mem_rec),
        .wb_rec  (wb_rec)
    );

    // WB producers are covered by the write-through regfile
    assign unused_bits = ^{mem_rec.mem_read, wb_rec};

    // Compare ID sources against in-flight producers
    always_comb begin
        rs1_ex  = tag_match(ex_rec, hz.id_rs1);
        rs2_ex  = tag_match(ex_rec, hz.id_rs2);
        rs1_mem = tag_match(mem_rec, hz.id_rs1);
        rs2_mem = tag_match(mem_rec, hz.id_rs2);
    end

`ifdef FORWARDING_EN
    // Only a load in EX is too late to bypass
    always_comb begin
        raw_stall = hz.id_valid && ex_rec.mem_read
                    && (rs1_ex || rs2_ex);
    end
`else
    // Without bypass any EX/MEM producer blocks ID
    always_comb begin
        raw_stall = hz.id_valid
                    && (rs1_ex || rs2_ex || rs1_mem || rs2_mem);
    end
`endif

    // A taken branch squashes the stalled instruction anyway
    always_comb begin
        flush_ex    = raw_stall || hz.ex_branch_taken;
        hz.flush_ex = flush_ex;
        hz.flush_id = hz.ex_branch_taken;
        hz.stall_if = raw_stall && !hz.ex_branch_taken;
        hz.stall_id = raw_stall && !hz.ex_branch_taken;
    end

`ifdef FORWARDING_EN
    fwd_sel_t fwd_a_d, fwd_a_q;
    fwd_sel_t fwd_b_d, fwd_b_q;

    // Select codes follow the instruction into EX; bubbles read the regfile
    always_comb begin
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        if (hz.id_valid && !flush_ex) begin
            fwd_a_d = fwd_pick(rs1_ex, rs1_mem);
            fwd_b_d = fwd_pick(rs2_ex, rs2_mem);
        end
    end

    // Hold selects for the whole EX cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign hz.fwd_a_op = fwd_a_q;
    assign hz.fwd_b_op = fwd_b_q;
`else
    assign hz.fwd_a_op = FWD_RF;
    assign hz.fwd_b_op = FWD_RF;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed and random bench for hazard_unit against a history-based model.
// Works with FORWARDING_EN defined or undefined.
module tb_hazard_unit;

    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       we;
        bit       ld;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    // hist[0] entered EX at the last edge, hist[1] the edge before
    ent_t     hist[$];
    bit [1:0] exp_a = 2'b00;
    bit [1:0] exp_b = 2'b00;

    hazard_unit_if hif ();

    hazard_unit dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] obs,
                         input logic [1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit prod(int k, bit [4:0] rs);
        if (hist.size() <= k) return 1'b0;
        return hist[k].v && hist[k].we && hist[k].rd == rs && rs != 5'd0;
    endfunction

    function automatic bit [1:0] pick(bit v, bit bub, bit in_ex, bit in_mem);
`ifdef FORWARDING_EN
        if (!v || bub) return 2'b00;
        if (in_ex) return 2'b01;
        if (in_mem) return 2'b10;
        return 2'b00;
`else
        return 2'b00;
`endif
    endfunction

    task automatic step(input bit r, input bit v,
                        input bit [4:0] s1, input bit [4:0] s2,
                        input bit [4:0] d, input bit we,
                        input bit ld, input bit br);
        bit       haz;
        bit       fex;
        bit [1:0] na;
        bit [1:0] nb;
        ent_t     e;
        @(negedge clk);
        rst                 = r;
        hif.id_valid        = v;
        hif.id_rs1          = s1;
        hif.id_rs2          = s2;
        hif.id_rd           = d;
        hif.id_reg_write    = we;
        hif.id_mem_read     = ld;
        hif.ex_branch_taken = br;
        #1;
`ifdef FORWARDING_EN
        haz = v && hist.size() > 0 && hist[0].ld
              && (prod(0, s1) || prod(0, s2));
`else
        haz = v && (prod(0, s1) || prod(0, s2)
                    || prod(1, s1) || prod(1, s2));
`endif
        fex = haz || br;
        if (!r) begin
            check("stall_if", {1'b0, hif.stall_if}, {1'b0, haz && !br});
            check("stall_id", {1'b0, hif.stall_id}, {1'b0, haz && !br});
            check("flush_id", {1'b0, hif.flush_id}, {1'b0, br});
            check("flush_ex", {1'b0, hif.flush_ex}, {1'b0, fex});
        end
        na = pick(v, fex, prod(0, s1), prod(1, s1));
        nb = pick(v, fex, prod(0, s2), prod(1, s2));
        @(posedge clk);
        #1;
        if (r) begin
            hist.delete();
            exp_a = 2'b00;
            exp_b = 2'b00;
        end else begin
            e.v  = v && !fex;
            e.rd = d;
            e.we = we;
            e.ld = ld;
            hist.push_front(e);
            if (hist.size() > 3) void'(hist.pop_back());
            exp_a = na;
            exp_b = nb;
        end
        check("fwd_a_op", hif.fwd_a_op, exp_a);
        check("fwd_b_op", hif.fwd_b_op, exp_b);
    endtask

    initial begin
        hif.id_valid        = 1'b0;
        hif.id_rs1          = '0;
        hif.id_rs2          = '0;
        hif.id_rd           = '0;
        hif.id_reg_write    = 1'b0;
        hif.id_mem_read     = 1'b0;
        hif.ex_branch_taken = 1'b0;

        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // add x5 ; add x6,x5,x1
        step(0, 1, 1, 2, 5, 1, 0, 0);
        step(0, 1, 5, 1, 6, 1, 0, 0);
        step(0, 1, 5, 1, 6, 1, 0, 0);
        step(0, 1, 5, 1, 6, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // x5 producer, independent, consumer in rs2
        step(0, 1, 1, 2, 5, 1, 0, 0);
        step(0, 1, 3, 4, 9, 1, 0, 0);
        step(0, 1, 1, 5, 10, 1, 0, 0);
        step(0, 1, 1, 5, 10, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // two writes to x5, then consumer
        step(0, 1, 1, 2, 5, 1, 0, 0);
        step(0, 1, 3, 4, 5, 1, 0, 0);
        step(0, 1, 5, 3, 11, 1, 0, 0);
        step(0, 1, 5, 3, 11, 1, 0, 0);
        step(0, 1, 5, 3, 11, 1, 0, 0);

        // lw x7 ; add x8,x7,x7 held in ID during the stall
        step(0, 1, 2, 0, 7, 1, 1, 0);
        step(0, 1, 7, 7, 8, 1, 0, 0);
        step(0, 1, 7, 7, 8, 1, 0, 0);
        step(0, 1, 7, 7, 8, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // lw x7 in EX, consumer in ID, branch taken
        step(0, 1, 2, 0, 7, 1, 1, 0);
        step(0, 1, 7, 1, 8, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // write x0 then read x0
        step(0, 1, 1, 2, 0, 1, 0, 0);
        step(0, 1, 0, 0, 12, 1, 0, 0);
        step(0, 1, 0, 0, 12, 1, 0, 0);

        // reset in the middle of a stall
        step(0, 1, 1, 2, 5, 1, 1, 0);
        step(0, 1, 5, 5, 6, 1, 0, 0);
        step(1, 1, 5, 5, 6, 1, 0, 0);
        step(0, 1, 5, 5, 6, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            bit       r;
            bit       we;
            r  = ($urandom_range(0, 59) == 0);
            we = ($urandom_range(0, 3) != 0);
            step(r, $urandom_range(0, 4) != 0,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), we,
                 we && ($urandom_range(0, 2) == 0),
                 $urandom_range(0, 7) == 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline control block that generates the 2-bit forwarding select codes consumed by the EX-stage operand muxes, and the stall/flush controls for the 5-stage RISC-V core. It tracks destination-register tags for EX/MEM/WB internally, compares them against the instruction leaving ID, and registers the select codes so they are valid for that instruction's whole EX cycle. It also detects load-use hazards (one-cycle stall) and taken-branch flushes.

## Interface
- REG_ADDR_W, 5, register index width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  REG_ADDR_W  source registers of ID instruction
- id_rd  in  REG_ADDR_W  destination of ID instruction
- id_reg_write  in  1  ID instruction writes rd
- id_mem_read  in  1  ID instruction is a load
- ex_branch_taken  in  1  branch/jump in EX resolved taken this cycle
- fwd_a_op, fwd_b_op  out  2  select for EX operand A/B (registered)
- stall_if, stall_id  out  1  hold PC / hold IF-ID register
- flush_id  out  1  invalidate IF-ID register at next edge
- flush_ex  out  1  insert bubble into ID-EX at next edge

## Operation
- Select encoding: 2'b00 regfile value, 2'b01 MEM-stage result, 2'b10 WB-stage result; 2'b11 never driven.
- Internal records EX, MEM, WB: {valid, rd, reg_write, mem_read}. Each edge: WB<=MEM, MEM<=EX; EX<=ID fields, or bubble (valid=0) when flush_ex.
- Match rule (per source rs vs record R): R.valid & R.reg_write & R.rd==rs & rs!=0. x0 never matches.
- Forward select for ID instruction, latched into fwd_*_op at the edge it enters EX: match EX record -> 01; else match MEM record -> 10; else 00. Double hazard (EX and MEM both match) -> 01 (newest).
- Load-use: EX record mem_read & match(id_rs1 or id_rs2) & id_valid -> stall_if=stall_id=1, flush_ex=1 for one cycle. Following cycle the load is in MEM; dependent instruction enters EX with select 10.
- Branch: ex_branch_taken -> flush_id=1, flush_ex=1, stall_if=stall_id=0. Branch overrides a simultaneous load-use stall.
- Bubble entering EX latches fwd_*_op=00.

## Timing
- stall_*, flush_*: combinational from current inputs and registered records, same cycle.
- fwd_*_op: registered, one edge after the ID-cycle compare; stable for the EX cycle.
- Reset (rst=1 at an edge): all records invalid, fwd_*_op=00; stall/flush outputs 0 while records invalid and ex_branch_taken=0. Reset mid-stall aborts the stall; no state survives.
- Regfile write in WB is visible to ID read in the same cycle (write-through regfile); WB-stage producers never require ID stalls.

## Configuration
- FORWARDING_EN defined: behaviour above.
- Undefined: fwd_*_op tied 00; ID stalls (stall_if=stall_id=flush_ex=1) while any source matches the EX or MEM record (any producer, not only loads). Branch priority unchanged.

## Structure
- hazard_pkg: FWD_RF/FWD_MEM/FWD_WB constants, tag record typedef, REG_ADDR_W default.
- Sub-module hazard_tag_pipe: EX/MEM/WB record shift register with bubble insert and reset.

## Test plan
- add x5 then add x6,x5,x1 back-to-back -> dependent EX cycle fwd_a_op=01, fwd_b_op=00, no stall.
- x5 producer followed by independent instr then consumer of x5 in rs2 -> fwd_b_op=10.
- Two writes to x5 then consumer -> fwd_a_op=01 (double hazard newest).
- lw x7 then add x8,x7,x7 -> one cycle stall_if=stall_id=flush_ex=1, then fwd_a_op=fwd_b_op=10.
- lw x7 in EX with ID consumer and ex_branch_taken=1 -> flush_id=flush_ex=1, stall=0; write to x0 then read x0 -> select 00.
- FORWARDING_EN undefined: add x5 then consumer -> two stall cycles, fwd 00; rst asserted mid-stall -> next cycle all outputs 0.
